// File: rtl/timestamp_pkg.sv
// Shared defaults and types for the timestamp capture array.
package timestamp_pkg;

    localparam int TS_WIDTH_DEFAULT = 40;
    localparam int TS_SYNC_DEFAULT  = 2;

    typedef logic [TS_WIDTH_DEFAULT-1:0] ts_count_t;

endpackage

// File: rtl/ts_channel.sv
// One capture channel: synchroniser, rising-edge detect, stamp register,
// ready flag and sticky missed-event flag. The timebase comes from the top.
import timestamp_pkg::*;

module ts_channel #(
    parameter int WIDTH       = TS_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = TS_SYNC_DEFAULT
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iLatch,
    input  logic             iRstLatch,
    input  logic [WIDTH-1:0] iCount,
    output logic [WIDTH-1:0] oStamp,
    output logic             oRdy,
    output logic             oMissed
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   started_r;
    logic                   armed_r;
    logic                   detect_s;
    logic [WIDTH-1:0]       stampNext_s;
    logic                   rdyNext_s;
    logic                   missedNext_s;

    // Synchroniser chain followed by the edge-history flop.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], iLatch};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Arm only after a genuine low sample, so a level held high across
    // reset release is not mistaken for an event.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            started_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            started_r <= 1'b1;
            armed_r   <= armed_r | (started_r & ~sync_r[0]);
        end
    end

    // Rising edge seen at the synchroniser output.
    always_comb begin
        detect_s = sync_r[SYNC_STAGES-1] & ~hist_r & armed_r;
    end

    // Capture decision: clear wins, then first event wins, later ones are missed.
    always_comb begin
        stampNext_s  = oStamp;
        rdyNext_s    = oRdy;
        missedNext_s = oMissed;
        if (iRstLatch) begin
            rdyNext_s    = 1'b0;
            missedNext_s = 1'b0;
        end else if (detect_s) begin
            if (!oRdy) begin
                stampNext_s = iCount;
                rdyNext_s   = 1'b1;
            end else begin
                missedNext_s = 1'b1;
            end
        end else begin
            rdyNext_s = oRdy;
        end
    end

    // Stamp, ready and missed registers.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oStamp  <= '0;
            oRdy    <= 1'b0;
            oMissed <= 1'b0;
        end else begin
            oStamp  <= stampNext_s;
            oRdy    <= rdyNext_s;
            oMissed <= missedNext_s;
        end
    end

endmodule

// File: rtl/timestamp_capture_array.sv
// Free-running timebase stamped by CHANNELS independent event inputs.
// Optional feature macro: TSC_SPAN_EN adds oSpan/oSpanValid, the registered
// difference between the last and first channel stamps.
import timestamp_pkg::*;

module timestamp_capture_array #(
    parameter int WIDTH       = TS_WIDTH_DEFAULT,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = TS_SYNC_DEFAULT
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic [CHANNELS-1:0]       iLatch,
    input  logic [CHANNELS-1:0]       iRstLatch,
    input  logic                      iCounterClear,
    output logic [WIDTH-1:0]          oCount,
    output logic                      oWrap,
    output logic [CHANNELS*WIDTH-1:0] oStamp,
    output logic [CHANNELS-1:0]       oRdy,
    output logic [CHANNELS-1:0]       oMissed
`ifdef TSC_SPAN_EN
    ,
    output logic [WIDTH-1:0]          oSpan,
    output logic                      oSpanValid
`endif
);

    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] countNext_s;
    logic             wrapNext_s;

    // Timebase next state: clear beats increment and suppresses the wrap pulse.
    always_comb begin
        countNext_s = oCount;
        wrapNext_s  = 1'b0;
        if (iCounterClear) begin
            countNext_s = '0;
            wrapNext_s  = 1'b0;
        end else begin
            countNext_s = oCount + COUNT_ONE;
            wrapNext_s  = &oCount;
        end
    end

    // Timebase and wrap registers.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oCount <= '0;
            oWrap  <= 1'b0;
        end else begin
            oCount <= countNext_s;
            oWrap  <= wrapNext_s;
        end
    end

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : gChan
            ts_channel #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) uChan (
                .iClk      (iClk),
                .iReset_n  (iReset_n),
                .iLatch    (iLatch[k]),
                .iRstLatch (iRstLatch[k]),
                .iCount    (oCount),
                .oStamp    (oStamp[k*WIDTH +: WIDTH]),
                .oRdy      (oRdy[k]),
                .oMissed   (oMissed[k])
            );
        end
    endgenerate

`ifdef TSC_SPAN_EN
    logic [WIDTH-1:0] spanDiff_s;

    // Distance from the first channel's stamp to the last channel's stamp.
    always_comb begin
        spanDiff_s = oStamp[(CHANNELS-1)*WIDTH +: WIDTH] - oStamp[0 +: WIDTH];
    end

    // Registered span and its valid flag (all channels ready).
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oSpan      <= '0;
            oSpanValid <= 1'b0;
        end else begin
            oSpan      <= spanDiff_s;
            oSpanValid <= &oRdy;
        end
    end
`endif

endmodule

// File: doc/timestamp_capture_array.md
Name: timestamp_capture_array

Overview:
- Parametrised successor to the two-channel latch counter.
- One free-running WIDTH-bit timebase, timestamped by CHANNELS independent event inputs.
- Each channel synchronises its asynchronous latch input, captures the timebase on the rising edge, and holds the value with a ready flag until software or its neighbour logic clears it.
- Adds missed-event detection, timebase wrap indication and a synchronous timebase clear.

Parameters:
- WIDTH, 40, timebase and stamp width in bits (8..64).
- CHANNELS, 2, number of capture channels (1..16).
- SYNC_STAGES, 2, synchroniser flops per latch input (2..4).

Ports:
- iClk  in  1  sole clock; all state on rising edge.
- iReset_n  in  1  asynchronous active-low reset.
- iLatch  in  CHANNELS  per-channel event inputs, asynchronous to iClk.
- iRstLatch  in  CHANNELS  per-channel level clear/disarm, synchronous to iClk.
- iCounterClear  in  1  synchronous timebase clear.
- oCount  out  WIDTH  current timebase value.
- oWrap  out  1  one-cycle pulse when the timebase wraps.
- oStamp  out  CHANNELS*WIDTH  captured values; channel k occupies bits [k*WIDTH +: WIDTH].
- oRdy  out  CHANNELS  per-channel stamp-valid flags.
- oMissed  out  CHANNELS  per-channel sticky missed-event flags.

Behaviour:
- Reset (iReset_n=0, asynchronous): all outputs are 0, including oCount, oWrap, oStamp, oRdy and oMissed. Synchroniser and edge-history flops are also 0.
- Timebase:
  - oCount increments by 1 every cycle, modulo 2^WIDTH.
  - The cycle in which oCount goes from all-ones to 0, oWrap=1 for exactly that cycle.
  - iCounterClear=1 forces oCount to 0 on the next edge, with no oWrap pulse.
  - Clear has priority over increment.
- Per-channel synchronisation and edge detection:
  - iLatch[k] passes through SYNC_STAGES flops, then one history flop.
  - Detect cycle D: synchronised=1 and history=0.
  - Latency: an input high at clock edge E0 produces D in the cycle after edge E0+SYNC_STAGES-1, and oRdy rises at the edge ending D.
  - Pulses shorter than one iClk period are not guaranteed to be captured.
- Capture at the edge ending D:
  - If iRstLatch[k]=1: event ignored; no flag changes.
  - Else if oRdy[k]=0: oStamp[k] <= oCount value during D (pre-clear value, even if iCounterClear=1 in D); oRdy[k] <= 1.
  - Else (oRdy[k]=1): oStamp[k] unchanged (first event wins); oMissed[k] <= 1.
- Clear:
  - While iRstLatch[k]=1, oRdy[k] and oMissed[k] are 0 from the next edge.
  - oStamp[k] retains its last value.
  - The channel re-arms on the first cycle with iRstLatch[k]=0.
  - An edge already detected in the same cycle that iRstLatch falls is captured normally.
- Channels are fully independent. Simultaneous edges on several channels each capture the identical oCount value.
- Asynchronous reset mid-operation discards any in-flight synchroniser state. No capture is produced from a level held high across reset release until it falls and rises again.
- No combinational paths from inputs to outputs.

Optional Feature:
- Macro TSC_SPAN_EN.
- Defined:
  - Adds output oSpan [WIDTH] and output oSpanValid [1].
  - oSpan = oStamp[CHANNELS-1] - oStamp[0], modulo 2^WIDTH, registered.
  - oSpanValid=1 the edge after all oRdy bits are 1, and 0 the edge after any oRdy bit falls.
  - Both reset to 0.
  - With CHANNELS=1: oSpan=0 and oSpanValid follows oRdy[0] delayed one cycle.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package timestamp_pkg: TS_WIDTH_DEFAULT=40, TS_SYNC_DEFAULT=2, and typedef ts_count_t for the default WIDTH-bit vector.
- Sub-module ts_channel, one per channel via generate. It holds the synchroniser, edge detect, capture register, oRdy and oMissed, and takes the shared oCount as input.
- The top level owns the timebase, the oWrap logic and the optional span logic.

Test Plan:
1. Reset, then hold iLatch[0] low for 100 cycles -> oCount=100 at cycle 100; oRdy=0, oStamp=0, oWrap never asserted.
2. Raise iLatch[0] sampled high at the edge where oCount=50 (SYNC_STAGES=2) -> oRdy[0] rises 2 edges later; oStamp[0]=51, oMissed[0]=0.
3. Raise iLatch[1] again with oRdy[1]=1 -> oStamp[1] unchanged, oMissed[1]=1. Pulse iRstLatch[1] for 1 cycle -> oRdy[1]=0, oMissed[1]=0; the next iLatch[1] edge re-captures.
4. WIDTH=8: run 256 cycles from reset -> oWrap is a single one-cycle pulse as oCount 255->0. Assert iCounterClear at oCount=17 -> next oCount=0, no oWrap.
5. Raise iLatch[0] and iLatch[1] high at the same edge -> both oStamp values equal. Hold iRstLatch[0]=1 during a further iLatch[0] edge -> no capture and no missed flag.
6. TSC_SPAN_EN: ch0 captures 1000, ch1 captures 1250 -> oSpan=250 and oSpanValid=1 one edge after both ready. Swap the event order so ch1=10, ch0=20, WIDTH=40 -> oSpan=2^40-10.
